yarp_alu_arbiter: RTL and testbench

Shares the single yarp ALU between two requesters: req0 is the execute pipeline and req1 is the address-generation/debug path. It arbitrates round-robin, captures the winner's operands and drives them to the ALU, then registers the result. It returns the result through a valid/ready response channel. It honours the cache-busy stall and keeps a saturating stall-cycle counter.

---
 rtl/yarp_pkg.sv | 18 +
 rtl/yarp_rr_arb2.sv | 13 +
 rtl/yarp_alu_arbiter.sv | 98 +++++++++
 tb/tb_yarp_alu_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// yarp_pkg: shared ALU op encodings and arbiter state type
package yarp_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLL = 4'd2;
    localparam logic [3:0] OP_SRL = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_t;

endpackage

// File: rtl/yarp_rr_arb2.sv
// yarp_rr_arb2: combinational two-way round-robin picker
module yarp_rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_gnt,
    output logic [1:0] o_gnt_onehot,
    output logic       o_gnt_idx
);

    // a lone requester wins; on a tie the one not granted last time wins
    assign o_gnt_idx    = (i_valid == 2'b11) ? ~i_last_gnt : i_valid[1];
    assign o_gnt_onehot = (i_valid == 2'b00) ? 2'b00 : (o_gnt_idx ? 2'b10 : 2'b01);

endmodule

// File: rtl/yarp_alu_arbiter.sv
// yarp_alu_arbiter: shares the yarp ALU between two requesters with a valid/ready response channel
module yarp_alu_arbiter
    import yarp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_opr_a_i,
    input  logic [DATA_W-1:0] req0_opr_b_i,
    input  logic [OP_W-1:0]   req0_op_sel_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_opr_a_i,
    input  logic [DATA_W-1:0] req1_opr_b_i,
    input  logic [OP_W-1:0]   req1_op_sel_i,
    output logic [DATA_W-1:0] alu_opr_a_o,
    output logic [DATA_W-1:0] alu_opr_b_o,
    output logic [OP_W-1:0]   alu_op_sel_o,
    input  logic [DATA_W-1:0] alu_res_i,
    input  logic              stall_i,
    output logic [1:0]        rsp_valid_o,
    input  logic [1:0]        rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    arb_state_t        r_state;
    logic              r_last_gnt;
    logic              r_owner;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_res;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        w_gnt;
    logic              w_gnt_idx;
    logic              w_accept;

    yarp_rr_arb2 u_arb (
        .i_valid      ({req1_valid_i, req0_valid_i}),
        .i_last_gnt   (r_last_gnt),
        .o_gnt_onehot (w_gnt),
        .o_gnt_idx    (w_gnt_idx)
    );

    // ready is only offered while idle, unstalled and out of reset
    assign w_accept     = reset_n && (r_state == IDLE) && !stall_i && (w_gnt != 2'b00);
    assign req0_ready_o = w_accept && w_gnt[0];
    assign req1_ready_o = w_accept && w_gnt[1];

    // the ALU only sees latched operands, and only while an op is issuing
    assign alu_opr_a_o  = (r_state == ISSUE) ? r_opa : '0;
    assign alu_opr_b_o  = (r_state == ISSUE) ? r_opb : '0;
    assign alu_op_sel_o = (r_state == ISSUE) ? r_op : OP_W'(OP_ADD);

    assign rsp_valid_o  = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data_o   = (r_state == RESP) ? r_res : '0;
    assign stall_cnt_o  = r_cnt;

    // accept -> issue -> respond sequencing, one op outstanding at a time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_owner    <= 1'b0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_op       <= OP_W'(OP_ADD);
            r_res      <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state    <= ISSUE;
                    r_owner    <= w_gnt_idx;
                    r_last_gnt <= w_gnt_idx;
                    r_opa      <= w_gnt_idx ? req1_opr_a_i : req0_opr_a_i;
                    r_opb      <= w_gnt_idx ? req1_opr_b_i : req0_opr_b_i;
                    r_op       <= w_gnt_idx ? req1_op_sel_i : req0_op_sel_i;
                end
                ISSUE: if (!stall_i) begin
                    r_res   <= alu_res_i;
                    r_state <= RESP;
                end else if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                RESP: if (rsp_ready_i[r_owner]) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_yarp_alu_arbiter.sv
// tb_yarp_alu_arbiter: table-driven plus randomized checks against a transaction-level model
module tb_yarp_alu_arbiter;
    import yarp_pkg::*;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0, b0;
        logic [3:0]  o0;
        logic [31:0] a1, b1;
        logic [3:0]  o1;
        int          stall;
        int          bp;
        int          gnt;
        logic [31:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [31:0] req0_opr_a_i, req0_opr_b_i, req1_opr_a_i, req1_opr_b_i;
    logic [3:0]  req0_op_sel_i, req1_op_sel_i;
    logic [31:0] alu_opr_a_o, alu_opr_b_o, alu_res_i;
    logic [3:0]  alu_op_sel_o;
    logic        stall_i;
    logic [1:0]  rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [15:0] stall_cnt_o;

    int n_vec = 0;
    int n_bad = 0;
    int model_last;
    int exp_cnt;

    yarp_alu_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req0_valid_i  (req0_valid_i),
        .req0_ready_o  (req0_ready_o),
        .req0_opr_a_i  (req0_opr_a_i),
        .req0_opr_b_i  (req0_opr_b_i),
        .req0_op_sel_i (req0_op_sel_i),
        .req1_valid_i  (req1_valid_i),
        .req1_ready_o  (req1_ready_o),
        .req1_opr_a_i  (req1_opr_a_i),
        .req1_opr_b_i  (req1_opr_b_i),
        .req1_op_sel_i (req1_op_sel_i),
        .alu_opr_a_o   (alu_opr_a_o),
        .alu_opr_b_o   (alu_opr_b_o),
        .alu_op_sel_o  (alu_op_sel_o),
        .alu_res_i     (alu_res_i),
        .stall_i       (stall_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb alu_res_i = alu_f(alu_op_sel_o, alu_opr_a_o, alu_opr_b_o);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t t, input string nm);
        logic [1:0]  oh;
        logic [31:0] ea, eb;
        logic [3:0]  eo;
        oh = (t.gnt == 1) ? 2'b10 : 2'b01;
        ea = (t.gnt == 1) ? t.a1 : t.a0;
        eb = (t.gnt == 1) ? t.b1 : t.b0;
        eo = (t.gnt == 1) ? t.o1 : t.o0;
        @(negedge clk);
        chk({nm, ".idle_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        chk({nm, ".idle_alu_a"}, 64'(alu_opr_a_o), 64'd0);
        chk({nm, ".idle_alu_op"}, 64'(alu_op_sel_o), 64'(OP_ADD));
        {req1_valid_i, req0_valid_i} = t.v;
        req0_opr_a_i = t.a0; req0_opr_b_i = t.b0; req0_op_sel_i = t.o0;
        req1_opr_a_i = t.a1; req1_opr_b_i = t.b1; req1_op_sel_i = t.o1;
        stall_i = 1'b0;
        rsp_ready_i = (t.bp > 0) ? ~oh : 2'b11;
        #1 chk({nm, ".grant"}, 64'({req1_ready_o, req0_ready_o}), 64'(oh));
        @(negedge clk);
        stall_i = (t.stall > 0);
        #1;
        chk({nm, ".alu_a"}, 64'(alu_opr_a_o), 64'(ea));
        chk({nm, ".alu_b"}, 64'(alu_opr_b_o), 64'(eb));
        chk({nm, ".alu_op"}, 64'(alu_op_sel_o), 64'(eo));
        chk({nm, ".issue_ready"}, 64'({req1_ready_o, req0_ready_o}), 64'd0);
        for (int i = 0; i < t.stall; i++) begin
            @(negedge clk);
            if (i < 4 || i == t.stall - 1) begin
                #1;
                chk({nm, ".stall_alu_a"}, 64'(alu_opr_a_o), 64'(ea));
                chk({nm, ".stall_alu_op"}, 64'(alu_op_sel_o), 64'(eo));
            end
        end
        stall_i = 1'b0;
        exp_cnt = (exp_cnt + t.stall > 65535) ? 65535 : exp_cnt + t.stall;
        #1 chk({nm, ".stall_cnt"}, 64'(stall_cnt_o), 64'(exp_cnt));
        @(negedge clk);
        for (int i = 0; i < t.bp; i++) begin
            #1;
            chk({nm, ".bp_rsp_valid"}, 64'(rsp_valid_o), 64'(oh));
            chk({nm, ".bp_rsp_data"}, 64'(rsp_data_o), 64'(t.data));
            chk({nm, ".bp_ready"}, 64'({req1_ready_o, req0_ready_o}), 64'd0);
            @(negedge clk);
        end
        rsp_ready_i = 2'b11;
        #1;
        chk({nm, ".rsp_valid"}, 64'(rsp_valid_o), 64'(oh));
        chk({nm, ".rsp_data"}, 64'(rsp_data_o), 64'(t.data));
        model_last = t.gnt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t t;
        logic [3:0] ops[8] = '{OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_AND, OP_OR, OP_XOR, 4'hF};
        tbl[0] = '{2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'hFF, OP_XOR, 0, 0, 0, 32'd7};
        tbl[1] = '{2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'hFF, OP_XOR, 0, 0, 1, 32'h0F};
        tbl[2] = '{2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'hFF, OP_XOR, 0, 0, 0, 32'd7};
        tbl[3] = '{2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'hFF, OP_XOR, 0, 0, 1, 32'h0F};
        tbl[4] = '{2'b01, 32'd5, 32'd7, OP_ADD, 32'd0, 32'd0, OP_ADD, 0, 0, 0, 32'd12};
        tbl[5] = '{2'b10, 32'd0, 32'd0, OP_ADD, 32'd1, 32'd4, OP_SLL, 3, 0, 1, 32'd16};
        tbl[6] = '{2'b11, 32'hFF00, 32'h0FF0, OP_AND, 32'd9, 32'd9, OP_OR, 0, 5, 0, 32'h0F00};
        reset_n = 1'b0;
        stall_i = 1'b0;
        rsp_ready_i = 2'b11;
        {req1_valid_i, req0_valid_i} = 2'b01;
        req0_opr_a_i = 32'd1; req0_opr_b_i = 32'd2; req0_op_sel_i = OP_ADD;
        req1_opr_a_i = 32'd0; req1_opr_b_i = 32'd0; req1_op_sel_i = OP_ADD;
        model_last = 1;
        exp_cnt = 0;
        #3;
        chk("rst.ready", 64'({req1_ready_o, req0_ready_o}), 64'd0);
        chk("rst.rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst.rsp_data", 64'(rsp_data_o), 64'd0);
        chk("rst.alu_a", 64'(alu_opr_a_o), 64'd0);
        chk("rst.alu_op", 64'(alu_op_sel_o), 64'(OP_ADD));
        chk("rst.stall_cnt", 64'(stall_cnt_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        {req1_valid_i, req0_valid_i} = 2'b00;
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) run_op(tbl[i], $sformatf("tbl%0d", i));
        @(negedge clk);
        stall_i = 1'b1;
        {req1_valid_i, req0_valid_i} = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1 chk("idle_stall.ready", 64'({req1_ready_o, req0_ready_o}), 64'd0);
            @(negedge clk);
            chk("idle_stall.alu_op", 64'(alu_op_sel_o), 64'(OP_ADD));
        end
        stall_i = 1'b0;
        {req1_valid_i, req0_valid_i} = 2'b00;
        for (int k = 0; k < 40; k++) begin
            t.v = 2'($urandom_range(1, 3));
            t.a0 = $urandom; t.b0 = $urandom; t.o0 = ops[$urandom_range(0, 7)];
            t.a1 = $urandom; t.b1 = $urandom; t.o1 = ops[$urandom_range(0, 7)];
            t.stall = $urandom_range(0, 3);
            t.bp = $urandom_range(0, 3);
            t.gnt = (t.v == 2'b11) ? 1 - model_last : (t.v == 2'b10 ? 1 : 0);
            t.data = (t.gnt == 1) ? alu_f(t.o1, t.a1, t.b1) : alu_f(t.o0, t.a0, t.b0);
            run_op(t, $sformatf("rnd%0d", k));
        end
        @(negedge clk);
        {req1_valid_i, req0_valid_i} = 2'b01;
        req0_opr_a_i = 32'd1; req0_opr_b_i = 32'd1; req0_op_sel_i = OP_ADD;
        #1 chk("mid_rst.grant", 64'({req1_ready_o, req0_ready_o}), 64'b01);
        @(negedge clk);
        {req1_valid_i, req0_valid_i} = 2'b00;
        #1 chk("mid_rst.issue_alu_a", 64'(alu_opr_a_o), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst.alu_a", 64'(alu_opr_a_o), 64'd0);
        chk("mid_rst.rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("mid_rst.stall_cnt", 64'(stall_cnt_o), 64'd0);
        model_last = 1;
        exp_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("mid_rst.no_rsp", 64'(rsp_valid_o), 64'd0);
        end
        run_op(tbl[0], "post_rst");
        t = '{2'b01, 32'd2, 32'd3, OP_ADD, 32'd0, 32'd0, OP_ADD, 65539, 0, 0, 32'd5};
        run_op(t, "sat");
        @(negedge clk);
        {req1_valid_i, req0_valid_i} = 2'b00;
        #1 chk("sat.hold", 64'(stall_cnt_o), 64'hFFFF);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
